// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the board counter sequencer: state encoding and counter width.
package counter_ctrl_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer plus stability counter, one press pulse per accepted press.
module btn_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clock,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic          armed;
  logic [CW-1:0] cnt;

  // Synchronizer resets high and disarmed, so a button held through reset must be released before it counts.
  // While armed we time a stable high; while disarmed we time a stable low before re-arming.
  always_ff @(posedge clock) begin
    if (rst) begin
      meta  <= 1'b1;
      sync  <= 1'b1;
      armed <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      meta  <= btn_raw;
      sync  <= meta;
      press <= 1'b0;
      if (sync == armed) begin
        if (cnt == LAST) begin
          cnt   <= '0;
          armed <= ~armed;
          press <= armed;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Run/pause/load sequencer for the 4-bit board counter: debounced buttons, step prescaler and control FSM.
module counter_seq_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int DIVISOR    = 100000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             btn_start,
  input  logic             btn_stop,
  input  logic             btn_load,
  input  logic [CNT_W-1:0] sw_in,
  input  logic             sw_dir,
  input  logic             sw_wrap,
  input  logic [CNT_W-1:0] cnt_q,
  output logic             cnt_load,
  output logic [CNT_W-1:0] cnt_load_val,
  output logic             cnt_step,
  output logic             cnt_dir,
  output logic [1:0]       state,
  output logic             run_led,
  output logic             done_led
);

  localparam int PW = (DIVISOR < 2) ? 1 : $clog2(DIVISOR);
  localparam logic [PW-1:0] PLAST = PW'(DIVISOR - 1);

  logic start_p, stop_p, load_p;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clock(clock), .rst(rst), .btn_raw(btn_start), .press(start_p)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_stop (
    .clock(clock), .rst(rst), .btn_raw(btn_stop), .press(stop_p)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (
    .clock(clock), .rst(rst), .btn_raw(btn_load), .press(load_p)
  );

  state_t           cur, nxt_state;
  logic [PW-1:0]    presc, nxt_presc;
  logic             nxt_load, nxt_step;
  logic [CNT_W-1:0] nxt_load_val;
  logic             tick, limit;

  assign tick  = (cur == ST_RUN) && (presc == PLAST);
  assign limit = cnt_dir ? (cnt_q == {CNT_W{1'b1}}) : (cnt_q == '0);
  assign state = cur;

  // Prescaler free-runs through every RUN cycle; load > stop > start > tick, losers are dropped.
  always_comb begin
    nxt_state    = cur;
    nxt_presc    = presc;
    nxt_load     = 1'b0;
    nxt_load_val = cnt_load_val;
    nxt_step     = 1'b0;
    if (cur == ST_RUN) nxt_presc = tick ? '0 : presc + 1'b1;
    if (load_p) begin
      nxt_load     = 1'b1;
      nxt_load_val = sw_in;
      nxt_presc    = '0;
      if (cur == ST_DONE) nxt_state = ST_IDLE;
    end else if (stop_p) begin
      case (cur)
        ST_RUN:            nxt_state = ST_PAUSE;
        ST_PAUSE, ST_DONE: nxt_state = ST_IDLE;
        default:           nxt_state = cur;
      endcase
    end else if (start_p) begin
      case (cur)
        ST_IDLE: begin
          nxt_state = ST_RUN;
          nxt_presc = '0;
        end
        ST_PAUSE: nxt_state = ST_RUN;
        ST_DONE: begin
          nxt_state    = ST_RUN;
          nxt_presc    = '0;
          nxt_load     = 1'b1;
          nxt_load_val = sw_in;
        end
        default: nxt_state = cur;
      endcase
    end else if (tick) begin
      if (limit && !sw_wrap) nxt_state = ST_DONE;
      else                   nxt_step  = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      cur          <= ST_IDLE;
      presc        <= '0;
      cnt_load     <= 1'b0;
      cnt_load_val <= '0;
      cnt_step     <= 1'b0;
      cnt_dir      <= 1'b0;
      run_led      <= 1'b0;
      done_led     <= 1'b0;
    end else begin
      cur          <= nxt_state;
      presc        <= nxt_presc;
      cnt_load     <= nxt_load;
      cnt_load_val <= nxt_load_val;
      cnt_step     <= nxt_step;
      cnt_dir      <= sw_dir;
      run_led      <= (nxt_state == ST_RUN);
      done_led     <= (nxt_state == ST_DONE);
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench for counter_seq_ctrl: reference model predicts load/step events and state each cycle.
module tb_counter_seq_ctrl;

  localparam int DIVISOR = 4;
  localparam int DEB     = 3;
  localparam int B_START = 1, B_STOP = 2, B_LOAD = 4;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0, btn_stop = 1'b0, btn_load = 1'b0;
  logic [3:0] sw_in = 4'd0;
  logic       sw_dir = 1'b0, sw_wrap = 1'b0;
  logic [3:0] cnt_q;
  logic       cnt_load, cnt_step, cnt_dir, run_led, done_led;
  logic [3:0] cnt_load_val;
  logic [1:0] state;

  always #5 clock = ~clock;

  counter_seq_ctrl #(.DIVISOR(DIVISOR), .DEB_CYCLES(DEB)) dut (
    .clock(clock), .rst(rst), .btn_start(btn_start), .btn_stop(btn_stop),
    .btn_load(btn_load), .sw_in(sw_in), .sw_dir(sw_dir), .sw_wrap(sw_wrap),
    .cnt_q(cnt_q), .cnt_load(cnt_load), .cnt_load_val(cnt_load_val),
    .cnt_step(cnt_step), .cnt_dir(cnt_dir), .state(state),
    .run_led(run_led), .done_led(done_led)
  );

  // Board counter datapath answering the controller's commands.
  always @(posedge clock) begin
    if (rst)           cnt_q <= 4'd0;
    else if (cnt_load) cnt_q <= cnt_load_val;
    else if (cnt_step) cnt_q <= cnt_dir ? cnt_q + 4'd1 : cnt_q - 4'd1;
  end

  typedef struct {
    bit          is_load;
    logic [3:0]  val;
    int unsigned stamp;
  } ev_t;

  ev_t         exp_q[$];
  int          n_vec = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;

  int       m_state, m_phase, m_val;
  bit       m_dir;
  bit [3:0] m_lv;
  bit       m_press[3], s1[3], s2[3], lvl[3], armed[3];
  int       run_len[3];

  task automatic push_ev(input bit is_load, input logic [3:0] val);
    ev_t e;
    e.is_load = is_load;
    e.val     = val;
    e.stamp   = cyc;
    exp_q.push_back(e);
  endtask

  // Reference model: spec rules applied per clock edge to the same inputs the DUT samples.
  always @(posedge clock) begin : model
    bit raw[3];
    bit st, sp, ld, tick, lim, s;
    cyc++;
    raw[0] = btn_start;
    raw[1] = btn_stop;
    raw[2] = btn_load;
    if (rst) begin
      m_state = 0; m_phase = 0; m_val = 0; m_dir = 0; m_lv = 4'd0;
      for (int b = 0; b < 3; b++) begin
        m_press[b] = 0; s1[b] = 1; s2[b] = 1; lvl[b] = 1; armed[b] = 0; run_len[b] = 0;
      end
    end else begin
      st   = m_press[0];
      sp   = m_press[1];
      ld   = m_press[2];
      tick = (m_state == 1) && (m_phase == DIVISOR - 1);
      if (ld) begin
        push_ev(1'b1, sw_in);
        m_val = sw_in; m_lv = sw_in; m_phase = 0;
        if (m_state == 3) m_state = 0;
      end else begin
        if (m_state == 1) m_phase = (m_phase + 1) % DIVISOR;
        if (sp) begin
          if (m_state == 1)      m_state = 2;
          else if (m_state != 0) m_state = 0;
        end else if (st) begin
          if (m_state == 0) begin
            m_state = 1; m_phase = 0;
          end else if (m_state == 2) begin
            m_state = 1;
          end else if (m_state == 3) begin
            push_ev(1'b1, sw_in);
            m_val = sw_in; m_lv = sw_in; m_state = 1; m_phase = 0;
          end
        end else if (tick) begin
          lim = m_dir ? (m_val == 15) : (m_val == 0);
          if (lim && !sw_wrap) m_state = 3;
          else begin
            push_ev(1'b0, {3'b000, sw_dir});
            m_val = (m_val + (sw_dir ? 1 : 15)) % 16;
          end
        end
      end
      m_dir = sw_dir;
      for (int b = 0; b < 3; b++) begin
        s = s2[b];
        if (s == lvl[b]) run_len[b]++;
        else begin
          run_len[b] = 1; lvl[b] = s;
        end
        m_press[b] = armed[b] && s && (run_len[b] == DEB);
        if (m_press[b]) armed[b] = 0;
        if (!s && run_len[b] >= DEB) armed[b] = 1;
        s2[b] = s1[b];
        s1[b] = raw[b];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: pops expected events when the DUT pulses and checks status outputs every cycle.
  always @(negedge clock) begin : monitor
    ev_t e;
    if (cyc > 0) begin
      while (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
        e = exp_q.pop_front();
        checkOutput(e.is_load ? "missed_load" : "missed_step", 32'd0, 32'd1);
      end
      if (cnt_load && cnt_step) checkOutput("load_step_overlap", 32'd1, 32'd0);
      if (cnt_load || cnt_step) begin
        if (exp_q.size() == 0 || exp_q[0].stamp != cyc) begin
          checkOutput("unexpected_event", {30'd0, cnt_load, cnt_step}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("event_kind", {30'd0, cnt_load, cnt_step}, e.is_load ? 32'd2 : 32'd1);
          if (e.is_load) checkOutput("load_val", {28'd0, cnt_load_val}, {28'd0, e.val});
          else           checkOutput("step_dir", {31'd0, cnt_dir}, {28'd0, e.val});
        end
      end
      checkOutput("state", {30'd0, state}, m_state);
      checkOutput("run_led", {31'd0, run_led}, {31'd0, m_state == 1});
      checkOutput("done_led", {31'd0, done_led}, {31'd0, m_state == 3});
      checkOutput("held_load_val", {28'd0, cnt_load_val}, {28'd0, m_lv});
    end
  end

  task automatic applyStimulus(input int mask, input int hold, input int gap);
    @(negedge clock);
    btn_start = mask[0];
    btn_stop  = mask[1];
    btn_load  = mask[2];
    repeat (hold) @(negedge clock);
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    btn_load  = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic check_reset_outputs();
    checkOutput("rst_cnt_load", {31'd0, cnt_load}, 32'd0);
    checkOutput("rst_cnt_load_val", {28'd0, cnt_load_val}, 32'd0);
    checkOutput("rst_cnt_step", {31'd0, cnt_step}, 32'd0);
    checkOutput("rst_cnt_dir", {31'd0, cnt_dir}, 32'd0);
    checkOutput("rst_state", {30'd0, state}, 32'd0);
    checkOutput("rst_leds", {30'd0, run_led, done_led}, 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int r, mask;
    sw_dir = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_outputs();
    rst = 1'b0;
    repeat (10) @(negedge clock);

    $display("[TB] load 5 from IDLE");
    sw_in = 4'b0101;
    applyStimulus(B_LOAD, 4, 8);

    $display("[TB] up-count, wrap mode");
    sw_wrap = 1'b1;
    applyStimulus(B_START, 4, 50);
    applyStimulus(B_STOP, 4, 8);
    applyStimulus(B_STOP, 4, 8);

    $display("[TB] halt mode reaching DONE, then restart from DONE");
    sw_in = 4'd13;
    applyStimulus(B_LOAD, 4, 8);
    sw_wrap = 1'b0;
    applyStimulus(B_START, 4, 20);
    sw_in = 4'd2;
    applyStimulus(B_START, 4, 10);

    $display("[TB] pause and resume");
    applyStimulus(B_STOP, 4, 8);
    applyStimulus(B_START, 4, 9);
    applyStimulus(B_STOP, 4, 10);
    applyStimulus(B_START, 4, 14);

    $display("[TB] debounce glitch then long press");
    applyStimulus(B_STOP, 4, 8);
    applyStimulus(B_STOP, 4, 8);
    applyStimulus(B_START, 2, 8);
    applyStimulus(B_START, 5, 10);

    $display("[TB] load and stop together in RUN");
    sw_in = 4'd9;
    applyStimulus(B_LOAD | B_STOP, 4, 10);

    $display("[TB] reset during RUN with start held");
    btn_start = 1'b1;
    rst = 1'b1;
    @(negedge clock);
    check_reset_outputs();
    rst = 1'b0;
    repeat (12) @(negedge clock);
    btn_start = 1'b0;
    repeat (10) @(negedge clock);

    $display("[TB] randomized phase");
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: mask = B_START;
        4, 5:       mask = B_STOP;
        6:          mask = B_LOAD;
        7:          mask = B_LOAD | B_STOP;
        8:          mask = B_START | B_STOP;
        default:    mask = 0;
      endcase
      sw_in   = 4'($urandom_range(0, 15));
      sw_wrap = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) sw_dir = ~sw_dir;
      applyStimulus(mask, $urandom_range(1, 6), $urandom_range(0, 14));
    end

    repeat (10) @(negedge clock);
    checkOutput("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Run/pause/load sequencer for the 4-bit board counter datapath on the Zybo Z7.
- Debounces three push-buttons and generates a single-cycle step strobe from a prescaler in the `clock` domain. No derived clocks.
- Drives load and step commands to the counter and reads back its value to detect the terminal count.
- Sits between the board buttons/switches and the counter register; its LEDs show status.

Parameters:
- DIVISOR, 100000000: `clock` cycles per step tick. Legal range is 2 or more.
- DEB_CYCLES, 1000000: number of consecutive synchronized-high cycles needed to accept a button press. Legal range is 1 or more.

Ports:
- clock  in  1  system clock
- rst  in  1  reset
- btn_start  in  1  raw asynchronous push-button, start or resume
- btn_stop  in  1  raw push-button, pause or stop
- btn_load  in  1  raw push-button, load switch value
- sw_in  in  4  switch value to load. Sampled only on the load decision cycle.
- sw_dir  in  1  1 = count up, 0 = count down. Sampled every cycle.
- sw_wrap  in  1  1 = wrap at the limit, 0 = halt at the limit
- cnt_q  in  4  current counter value, fed back from the datapath
- cnt_load  out  1  one-cycle pulse: counter takes cnt_load_val
- cnt_load_val  out  4  value to load. Held stable between loads.
- cnt_step  out  1  one-cycle pulse: counter moves by 1 in direction cnt_dir
- cnt_dir  out  1  direction qualifying cnt_step
- state  out  2  0 = IDLE, 1 = RUN, 2 = PAUSE, 3 = DONE
- run_led  out  1  high while in RUN
- done_led  out  1  high while in DONE

Behaviour:
- Reset and clock: reset `rst`, synchronous, active-high; clock `clock`.
  - Reset state: IDLE.
  - All outputs reset to 0. This includes cnt_load_val and the prescaler count.
  - All outputs are registered.
- Button path (per button):
  - 2-FF synchronizer, then a stability counter.
  - Once the synchronized level has been high for DEB_CYCLES consecutive cycles, emit exactly one press pulse for that press.
  - Re-arm only after the synchronized level has been low for DEB_CYCLES consecutive cycles.
  - A bounce shorter than DEB_CYCLES restarts the count.
  - Timing: the press pulse is high on cycle 2+DEB_CYCLES, counted from the first edge that samples the raw input high. The pulse lasts 1 cycle.
- Event priority in one cycle: load > stop > start > tick. A lower-priority event that coincides with a higher one is discarded, not deferred.
- Load event:
  - In every state: cnt_load_val <= sw_in and cnt_load = 1 on the next cycle.
  - The prescaler clears to 0.
  - Next state: IDLE from DONE. Unchanged from IDLE, RUN or PAUSE.
- Prescaler:
  - Counts 0..DIVISOR-1 only while in RUN. Holds its value in PAUSE.
  - Clears on entry to RUN from IDLE or DONE, and on load.
  - tick = (count == DIVISOR-1) while in RUN.
  - First tick occurs DIVISOR cycles after entering RUN from IDLE.
- State transitions:
  - IDLE: start -> RUN.
  - RUN: stop -> PAUSE.
  - RUN on tick:
    - limit = (cnt_dir ? cnt_q==15 : cnt_q==0).
    - If limit and sw_wrap=0: go to DONE, no step.
    - Otherwise: cnt_step = 1 on the next cycle. In wrap mode the datapath wraps 15->0 or 0->15.
  - PAUSE: start -> RUN, with the prescaler resuming from its held value. stop -> IDLE.
  - DONE:
    - start -> cnt_load pulse with the current sw_in, then RUN with the prescaler cleared.
    - stop -> IDLE.
- cnt_dir is registered from sw_dir. A direction change takes effect from the next tick.
- cnt_step and cnt_load are never high in the same cycle.
- Reset asserted mid-operation:
  - Everything returns to reset values on the next edge. Any in-flight debounce count is lost.
  - A button still held through reset release is not reported until it has been released and pressed again.

Decomposition:
- Package counter_ctrl_pkg holds:
  - the state encoding constants: ST_IDLE=0, ST_RUN=1, ST_PAUSE=2, ST_DONE=3
  - the counter width constant: CNT_W=4
- One sub-module, btn_debounce (parameter DEB_CYCLES; ports clock, rst, btn_raw, press), instantiated three times.
- The prescaler and the FSM are inline in counter_seq_ctrl.

Test Plan:
All scenarios use DIVISOR=4 and DEB_CYCLES=3. The bench includes a 4-bit counter model driven by cnt_load/cnt_step/cnt_dir.
1. Reset, then load: sw_in=0101, press load -> cnt_load pulses exactly once, cnt_load_val=0101, model=5, state stays IDLE.
2. Up-count in wrap mode: load 5, sw_dir=1, sw_wrap=1, press start -> first cnt_step 4 cycles after RUN entry, one step every 4 cycles after that, model sequence 6,7...15,0.
3. Halt mode: load 13, sw_dir=1, sw_wrap=0, start -> steps to 14, then 15, then state=DONE with done_led=1 and no further steps. Pressing start then gives cnt_load of sw_in and RUN.
4. Pause/resume: in RUN, press stop -> state=PAUSE, no steps. Press start -> next step arrives after the remaining prescaler cycles, not a full 4. Pressing stop twice from RUN gives IDLE.
5. Debounce: 2-cycle glitch on btn_start -> no press. Hold high for 5 cycles -> exactly one press, on cycle 5 after the first high sample.
6. Priority/reset: load and stop pulses land in the same cycle while in RUN -> load only, state stays RUN. rst asserted in RUN -> next cycle state=0 and all outputs 0.
